// File: rtl/data_sram_ctrl_pkg.sv
// Shared definitions for the data-side SRAM controller.
// Holds the FSM state encoding, the default access length and the
// active-low strobe levels used by the controller and its wait counter.
package data_sram_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } sram_state_t;

    localparam int WAIT_CYCLES_DEFAULT = 2;
    localparam int CNT_W               = 4;

    localparam logic CHIP_ENABLE    = 1'b0;
    localparam logic CHIP_DISABLE   = 1'b1;
    localparam logic WRITE_ENABLE   = 1'b0;
    localparam logic WRITE_DISABLE  = 1'b1;
    localparam logic OUTPUT_ENABLE  = 1'b0;
    localparam logic OUTPUT_DISABLE = 1'b1;

endpackage

// File: rtl/data_sram_ctrl_wait_cnt.sv
// Wait-state down-counter for the SRAM controller.
// Ports:
//   clk, rst   - clock, asynchronous active-high reset
//   load       - load load_val (takes priority over dec)
//   dec        - decrement by one; holds at zero
//   load_val   - value loaded at the start of an access
//   zero       - counter is at its terminal count
module sram_wait_cnt
    import data_sram_ctrl_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             dec,
    input  logic [CNT_W-1:0] load_val,
    output logic             zero
);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec && (cnt != '0)) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/data_sram_ctrl.sv
// Data-side asynchronous SRAM controller for the memory-access stage.
// A request is latched in IDLE, driven to the SRAM for WAIT_CYCLES cycles
// from registered copies only, and completes in DONE where load data is
// presented. The pipeline is stalled for WAIT_CYCLES+1 cycles per access.
//
//   state  | meaning
//   IDLE   | no access; a request raises stallreq_o and is latched
//   ACCESS | SRAM strobes active, wait counter running
//   DONE   | access finished; waits here while stall_i is high
//
// Ports:
//   clk, rst          - clock, asynchronous active-high reset
//   mem_ce_i/we_i     - request valid / store(1) or load(0)
//   mem_addr_i        - byte address, word-aligned use only
//   mem_sel_i         - byte lanes (bit 3 = [31:24])
//   mem_data_i        - store data
//   stall_i           - stall of the memory-access stage from elsewhere
//   mem_data_o        - load data (read-data register)
//   stallreq_o        - pipeline stall request
//   sram_*            - SRAM word address, data and active-low strobes
module data_sram_ctrl
    import data_sram_ctrl_pkg::*;
#(
    parameter int WAIT_CYCLES = WAIT_CYCLES_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_ce_i,
    input  logic        mem_we_i,
    input  logic [31:0] mem_addr_i,
    input  logic [3:0]  mem_sel_i,
    input  logic [31:0] mem_data_i,
    input  logic        stall_i,
    output logic [31:0] mem_data_o,
    output logic        stallreq_o,
    output logic [29:0] sram_addr_o,
    output logic [3:0]  sram_be_n_o,
    output logic [31:0] sram_data_o,
    input  logic [31:0] sram_data_i,
    output logic        sram_ce_n_o,
    output logic        sram_oe_n_o,
    output logic        sram_we_n_o
);

    localparam logic [CNT_W-1:0] WAIT_LOAD = CNT_W'(WAIT_CYCLES - 1);

    sram_state_t state, state_nxt;

    logic [29:0] addr_q;
    logic        we_q;
    logic [3:0]  sel_q;
    logic [31:0] data_q;
    logic [31:0] rdata_q;

    logic req_accept;
    logic cnt_zero;

    // Byte offset is resolved by the memory-access stage.
    logic unused_addr_lsb;
    assign unused_addr_lsb = ^mem_addr_i[1:0];

    assign req_accept = (state == ST_IDLE) && mem_ce_i;

    sram_wait_cnt u_wait_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (req_accept),
        .dec      (state == ST_ACCESS),
        .load_val (WAIT_LOAD),
        .zero     (cnt_zero)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:   if (mem_ce_i) state_nxt = ST_ACCESS;
            ST_ACCESS: if (cnt_zero) state_nxt = ST_DONE;
            ST_DONE:   if (!stall_i) state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    // The write strobe is released in the last ACCESS cycle so address
    // and data are held one cycle past the rising edge of we_n.
    always_comb begin
        stallreq_o  = 1'b0;
        sram_ce_n_o = CHIP_DISABLE;
        sram_oe_n_o = OUTPUT_DISABLE;
        sram_we_n_o = WRITE_DISABLE;
        sram_be_n_o = 4'hF;
        case (state)
            ST_IDLE: begin
                // rst gating keeps stallreq_o low while a request sits on
                // the inputs during reset.
                stallreq_o = mem_ce_i && !rst;
            end
            ST_ACCESS: begin
                stallreq_o  = 1'b1;
                sram_ce_n_o = CHIP_ENABLE;
                sram_be_n_o = ~sel_q;
                if (we_q) begin
                    sram_we_n_o = cnt_zero ? WRITE_DISABLE : WRITE_ENABLE;
                end else begin
                    sram_oe_n_o = OUTPUT_ENABLE;
                end
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q  <= '0;
            we_q    <= 1'b0;
            sel_q   <= '0;
            data_q  <= '0;
            rdata_q <= '0;
        end else begin
            if (req_accept) begin
                addr_q <= mem_addr_i[31:2];
                we_q   <= mem_we_i;
                sel_q  <= mem_sel_i;
                data_q <= mem_data_i;
            end
            if ((state == ST_ACCESS) && cnt_zero && !we_q) begin
                rdata_q <= sram_data_i;
            end
        end
    end

    assign sram_addr_o = addr_q;
    assign sram_data_o = data_q;
    assign mem_data_o  = rdata_q;

endmodule

// File: tb/tb_data_sram_ctrl.sv
module tb_data_sram_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        mem_ce_i = 1'b0;
    logic        mem_we_i = 1'b0;
    logic [31:0] mem_addr_i = '0;
    logic [3:0]  mem_sel_i = '0;
    logic [31:0] mem_data_i = '0;
    logic        stall_i = 1'b0;
    logic [31:0] sram_data_i = '0;

    logic [31:0] a_mem_data, b_mem_data;
    logic        a_stall, b_stall;
    logic [29:0] a_addr, b_addr;
    logic [3:0]  a_be_n, b_be_n;
    logic [31:0] a_data, b_data;
    logic        a_ce_n, b_ce_n, a_oe_n, b_oe_n, a_we_n, b_we_n;

    logic        use_b = 1'b0;
    logic [31:0] o_mem_data;
    logic        o_stall, o_ce_n, o_oe_n, o_we_n;
    logic [29:0] o_addr;
    logic [3:0]  o_be_n;
    logic [31:0] o_data;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    data_sram_ctrl #(.WAIT_CYCLES(2)) dut_a (
        .clk(clk), .rst(rst), .mem_ce_i(mem_ce_i), .mem_we_i(mem_we_i),
        .mem_addr_i(mem_addr_i), .mem_sel_i(mem_sel_i), .mem_data_i(mem_data_i),
        .stall_i(stall_i), .mem_data_o(a_mem_data), .stallreq_o(a_stall),
        .sram_addr_o(a_addr), .sram_be_n_o(a_be_n), .sram_data_o(a_data),
        .sram_data_i(sram_data_i), .sram_ce_n_o(a_ce_n), .sram_oe_n_o(a_oe_n),
        .sram_we_n_o(a_we_n)
    );

    data_sram_ctrl #(.WAIT_CYCLES(3)) dut_b (
        .clk(clk), .rst(rst), .mem_ce_i(mem_ce_i), .mem_we_i(mem_we_i),
        .mem_addr_i(mem_addr_i), .mem_sel_i(mem_sel_i), .mem_data_i(mem_data_i),
        .stall_i(stall_i), .mem_data_o(b_mem_data), .stallreq_o(b_stall),
        .sram_addr_o(b_addr), .sram_be_n_o(b_be_n), .sram_data_o(b_data),
        .sram_data_i(sram_data_i), .sram_ce_n_o(b_ce_n), .sram_oe_n_o(b_oe_n),
        .sram_we_n_o(b_we_n)
    );

    assign o_mem_data = use_b ? b_mem_data : a_mem_data;
    assign o_stall    = use_b ? b_stall    : a_stall;
    assign o_addr     = use_b ? b_addr     : a_addr;
    assign o_be_n     = use_b ? b_be_n     : a_be_n;
    assign o_data     = use_b ? b_data     : a_data;
    assign o_ce_n     = use_b ? b_ce_n     : a_ce_n;
    assign o_oe_n     = use_b ? b_oe_n     : a_oe_n;
    assign o_we_n     = use_b ? b_we_n     : a_we_n;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Issues one request and samples every cycle until the first cycle
    // without stallreq_o (DONE). Returns with the request still applied.
    // mode: 0 plain, 1 scramble live inputs during ACCESS, 2 drop mem_ce_i.
    int          r_stall, r_oe, r_ce, r_bad;
    logic [15:0] r_we_pat;
    logic [29:0] r_addr;
    logic [3:0]  r_be;

    task automatic do_access(input logic we, input logic [31:0] addr,
                             input logic [3:0] sel, input logic [31:0] wdata,
                             input logic [31:0] rdata, input int mode);
        bit started = 0;
        bit done = 0;
        r_stall = 0; r_oe = 0; r_ce = 0; r_bad = 0;
        r_we_pat = '0; r_addr = '0; r_be = '0;
        mem_ce_i = 1'b1; mem_we_i = we; mem_addr_i = addr;
        mem_sel_i = sel; mem_data_i = wdata; sram_data_i = rdata; stall_i = 1'b0;
        #1;
        for (int i = 0; i < 25; i++) begin
            if (i != 0) begin
                @(negedge clk);
                #1;
            end
            if (o_stall) begin
                r_stall++;
                started = 1;
            end else if (started) begin
                done = 1;
                break;
            end
            if (o_ce_n == 1'b0) begin
                r_ce++;
                if (!o_oe_n) r_oe++;
                r_we_pat = {r_we_pat[14:0], ~o_we_n};
                r_addr = o_addr;
                r_be = o_be_n;
                if (o_addr !== addr[31:2] || o_be_n !== ~sel || o_data !== wdata) r_bad++;
                if (r_ce == 1 && mode == 1) begin
                    mem_addr_i = ~addr; mem_sel_i = ~sel;
                    mem_data_i = ~wdata; mem_we_i = ~we;
                end
                if (r_ce == 1 && mode == 2) mem_ce_i = 1'b0;
            end
        end
        if (!done) check("access_timeout", 32'd1, 32'd0);
    endtask

    task automatic release_req();
        mem_ce_i = 1'b0;
        stall_i = 1'b0;
        @(negedge clk);
        #1;
    endtask

    initial begin
        int n;
        #2 rst = 1'b1;
        mem_ce_i = 1'b1;
        #1;
        check("rst_stall", o_stall, 0);
        check("rst_ce_n", o_ce_n, 1);
        check("rst_oe_n", o_oe_n, 1);
        check("rst_we_n", o_we_n, 1);
        check("rst_be_n", o_be_n, 4'hF);
        check("rst_addr", o_addr, 0);
        check("rst_sram_data", o_data, 0);
        check("rst_mem_data", o_mem_data, 0);
        check("rst_stall_b", b_stall, 0);
        @(negedge clk); #1;
        check("rst_stall_edge", o_stall, 0);
        @(negedge clk);
        rst = 1'b0; mem_ce_i = 1'b0;
        #1;

        // Load, WAIT_CYCLES=2
        do_access(1'b0, 32'h0000_0104, 4'hF, 32'h0, 32'hDEAD_BEEF, 0);
        check("ld_stall_cycles", r_stall, 3);
        check("ld_oe_cycles", r_oe, 2);
        check("ld_ce_cycles", r_ce, 2);
        check("ld_we_pat", r_we_pat, 0);
        check("ld_addr", r_addr, 30'h41);
        check("ld_hold", r_bad, 0);
        check("ld_data", o_mem_data, 32'hDEAD_BEEF);

        // Hold DONE with stall_i for 4 cycles, request still present
        stall_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); #1;
            check("hold_stall", o_stall, 0);
            check("hold_ce_n", o_ce_n, 1);
            check("hold_data", o_mem_data, 32'hDEAD_BEEF);
        end
        stall_i = 1'b0;
        @(negedge clk); #1;
        check("idle_after_stall", o_stall, 1);
        check("idle_ce_n", o_ce_n, 1);
        mem_ce_i = 1'b0;
        @(negedge clk); #1;
        check("idle_quiet_stall", o_stall, 0);
        check("idle_quiet_ce_n", o_ce_n, 1);

        // Back-to-back load then store with live inputs scrambled in ACCESS
        do_access(1'b0, 32'h0000_2008, 4'hF, 32'h0, 32'h0BAD_F00D, 1);
        check("b2b_ld_stall", r_stall, 3);
        check("b2b_ld_oe", r_oe, 2);
        check("b2b_ld_hold", r_bad, 0);
        check("b2b_ld_data", o_mem_data, 32'h0BAD_F00D);
        do_access(1'b1, 32'h0000_0030, 4'b1010, 32'hA5A5_5A5A, 32'h1111_1111, 1);
        check("b2b_st_stall", r_stall, 3);
        check("b2b_st_ce", r_ce, 2);
        check("b2b_st_oe", r_oe, 0);
        check("b2b_st_we_pat", r_we_pat, 16'b10);
        check("b2b_st_hold", r_bad, 0);
        check("b2b_st_rdata", o_mem_data, 32'h0BAD_F00D);
        release_req();

        // Flush: mem_ce_i dropped in the first ACCESS cycle
        do_access(1'b0, 32'h0000_0400, 4'hF, 32'h0, 32'h1357_9BDF, 2);
        check("fl_stall", r_stall, 3);
        check("fl_ce", r_ce, 2);
        check("fl_oe", r_oe, 2);
        check("fl_data", o_mem_data, 32'h1357_9BDF);
        n = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); #1;
            if (o_ce_n == 1'b0 || o_stall) n++;
        end
        check("fl_no_second", n, 0);

        // Reset between edges in the middle of ACCESS
        mem_ce_i = 1'b1; mem_we_i = 1'b0; mem_addr_i = 32'h0000_0200;
        mem_sel_i = 4'hF; mem_data_i = 32'h0; sram_data_i = 32'h7777_7777;
        @(negedge clk); #1;
        check("mid_in_access", o_ce_n, 0);
        #1 rst = 1'b1;
        #1;
        check("mid_rst_ce_n", o_ce_n, 1);
        check("mid_rst_oe_n", o_oe_n, 1);
        check("mid_rst_be_n", o_be_n, 4'hF);
        check("mid_rst_stall", o_stall, 0);
        check("mid_rst_addr", o_addr, 0);
        check("mid_rst_mem_data", o_mem_data, 0);
        @(negedge clk);
        rst = 1'b0; mem_ce_i = 1'b0;
        #1;
        do_access(1'b0, 32'hFFFF_FFFC, 4'b0110, 32'h0, 32'h5555_AAAA, 0);
        check("post_rst_stall", r_stall, 3);
        check("post_rst_addr", r_addr, 30'h3FFF_FFFF);
        check("post_rst_hold", r_bad, 0);
        check("post_rst_data", o_mem_data, 32'h5555_AAAA);
        release_req();

        // Store, WAIT_CYCLES=3, from a clean reset
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        use_b = 1'b1;
        #1;
        do_access(1'b1, 32'h0000_0080, 4'b0011, 32'h1234_5678, 32'hCAFE_F00D, 0);
        check("st_stall", r_stall, 4);
        check("st_ce", r_ce, 3);
        check("st_oe", r_oe, 0);
        check("st_we_pat", r_we_pat, 16'b110);
        check("st_be_n", r_be, 4'b1100);
        check("st_hold", r_bad, 0);
        check("st_rdata", o_mem_data, 0);
        release_req();
        check("st_idle_we_n", o_we_n, 1);
        check("st_idle_be_n", o_be_n, 4'hF);
        check("st_idle_data_held", o_data, 32'h1234_5678);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
